// File: rtl/flip_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// flip_event_arbiter_pkg
//   Shared definitions for the flip-handshake event arbiter:
//   - default constants for requester count, WAIT timeout and the width of
//     the optional per-requester merged-event counters
//   - FSM state encoding
//   - saturating increment helper for the merged-event counters
// -----------------------------------------------------------------------------
package flip_event_arbiter_pkg;

  // Default number of event requesters.
  localparam int NUM_REQ_DEF = 4;

  // Default number of clk cycles tolerated in WAIT before a timeout.
  localparam int TIMEOUT_DEF = 1024;

  // Width of each merged-event counter (saturates at all ones).
  localparam int DROP_CNT_W  = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (v == {DROP_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + DROP_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/flip_event_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans the pending vector starting at
//   last_grant_i+1 and wrapping from NUM_REQ-1 back to 0; the first set bit
//   found wins. last_grant_i itself is examined last, so a requester that was
//   just served only wins again when nobody else is waiting.
//
// Ports
//   pending_i     in  NUM_REQ  candidate requests
//   last_grant_i  in  ID_W     index granted most recently
//   valid_o       out 1        at least one pending bit is set
//   idx_o         out ID_W     chosen index (0 when valid_o is low)
// -----------------------------------------------------------------------------
module rr_pick
  import flip_event_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  int          cand_s;
  logic [ID_W-1:0] cand_idx_s;

  // Walk the offsets 1..NUM_REQ from the last grant and keep the first hit.
  always_comb begin
    valid_o    = 1'b0;
    idx_o      = '0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s     = (int'(last_grant_i) + off) % NUM_REQ;
      cand_idx_s = ID_W'(cand_s);
      if (!valid_o && pending_i[cand_idx_s]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx_s;
      end else begin
        valid_o = valid_o;
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/flip_event_arbiter.sv
// -----------------------------------------------------------------------------
// flip_event_arbiter
//   Collects rising edges on NUM_REQ event lines into a pending vector and
//   forwards them one at a time to a consumer over a toggle (flip) handshake.
//   A request is outstanding while req_flip != ack_flip; the consumer ends it
//   by making ack_flip equal req_flip. Requesters are served round-robin.
//   If the consumer does not answer within TIMEOUT cycles the arbiter raises
//   a sticky timeout_err and parks in HALT until clr_err, which withdraws the
//   outstanding request by copying ack_flip into req_flip.
//
// Optional feature (macro FLIP_EVENT_ARBITER_DROP_CNT_EN):
//   adds output drop_cnt, one saturating 8-bit counter per requester counting
//   events merged into an already pending bit; cleared by reset and clr_err.
//
// Ports
//   clk          in  1                 rising-edge clock
//   rstn         in  1                 asynchronous active-low reset
//   ev_in        in  NUM_REQ           event levels, one event per rising edge
//   ack_flip     in  1                 consumer acknowledge toggle
//   clr_err      in  1                 clears timeout_err, leaves HALT
//   req_flip     out 1                 request toggle
//   ev_id        out ID_W              requester carried by the current request
//   busy         out 1                 FSM not in IDLE
//   pending      out NUM_REQ           latched, not yet granted events
//   timeout_err  out 1                 sticky timeout flag
//   drop_cnt     out NUM_REQ*8         merged-event counters (macro only)
// -----------------------------------------------------------------------------
module flip_event_arbiter
  import flip_event_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = 2,            // must equal $clog2(NUM_REQ)
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           ev_in,
  input  logic                         ack_flip,
  input  logic                         clr_err,
  output logic                         req_flip,
  output logic [ID_W-1:0]              ev_id,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           pending,
  output logic                         timeout_err
`ifdef FLIP_EVENT_ARBITER_DROP_CNT_EN
  ,
  output logic [NUM_REQ*DROP_CNT_W-1:0] drop_cnt
`endif
);

  // The WAIT counter holds 0..TIMEOUT-1; reaching the top value with the
  // request still unanswered is the timeout.
  localparam int              CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e              state_q,       state_d;
  logic                req_flip_q,    req_flip_d;
  logic [ID_W-1:0]     ev_id_q,       ev_id_d;
  logic                busy_q,        busy_d;
  logic [NUM_REQ-1:0]  pending_q,     pending_d;
  logic                timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]     last_grant_q,  last_grant_d;
  logic [CNT_W-1:0]    cnt_q,         cnt_d;
  logic [NUM_REQ-1:0]  ev_prev_q;

  logic [NUM_REQ-1:0]  rise_s;
  logic [NUM_REQ-1:0]  grant_mask_s;
  logic                pick_valid_s;
  logic [ID_W-1:0]     pick_idx_s;

  // Event edges: current sample high, previous sample low.
  assign rise_s = ev_in & ~ev_prev_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .pending_i    (pending_q),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid_s),
    .idx_o        (pick_idx_s)
  );

  // Next-state logic for the FSM, the handshake outputs and the pending set.
  always_comb begin
    state_d       = state_q;
    req_flip_d    = req_flip_q;
    ev_id_d       = ev_id_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    grant_mask_s  = '0;

    // clr_err clears the flag in every state; HALT adds its own exit below.
    if (clr_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          req_flip_d   = ~req_flip_q;
          ev_id_d      = pick_idx_s;
          last_grant_d = pick_idx_s;
          grant_mask_s = NUM_REQ'(1) << pick_idx_s;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end else begin
          state_d      = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // The acknowledge only releases the arbiter; the next grant waits
        // for the following IDLE cycle.
        if (ack_flip == req_flip_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_err_d = 1'b1;
          state_d       = ST_HALT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_WAIT;
        end
      end

      ST_HALT: begin
        // Withdraw the unanswered request without issuing a new one.
        if (clr_err) begin
          req_flip_d = ack_flip;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_HALT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A fresh edge on the requester being granted survives the clear.
    pending_d = (pending_q & ~grant_mask_s) | rise_s;
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      req_flip_q    <= 1'b0;
      ev_id_q       <= '0;
      busy_q        <= 1'b0;
      pending_q     <= '0;
      timeout_err_q <= 1'b0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      ev_prev_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_flip_q    <= req_flip_d;
      ev_id_q       <= ev_id_d;
      busy_q        <= busy_d;
      pending_q     <= pending_d;
      timeout_err_q <= timeout_err_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      ev_prev_q     <= ev_in;
    end
  end

  assign req_flip    = req_flip_q;
  assign ev_id       = ev_id_q;
  assign busy        = busy_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

`ifdef FLIP_EVENT_ARBITER_DROP_CNT_EN
  logic [NUM_REQ-1:0]    drop_s;
  logic [DROP_CNT_W-1:0] drop_q [NUM_REQ];

  // An edge merges when its bit is already pending and not being granted.
  assign drop_s = rise_s & pending_q & ~grant_mask_s;

  // Per-requester saturating merged-event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        drop_q[i] <= '0;
      end
    end else if (clr_err) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        drop_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drop_s[i]) begin
          drop_q[i] <= sat_inc(drop_q[i]);
        end else begin
          drop_q[i] <= drop_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_drop_out
    assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = drop_q[g];
  end
`endif

endmodule
